// File: rtl/anim_overlay_ctrl.sv
// anim_overlay_ctrl: raster tracking, animation/background scheduling and pipelined sprite-ROM addressing
module anim_overlay_ctrl #(
    parameter int NUM_FRAMES  = 30,
    parameter int FRAME_DELAY = 4,
    parameter int NUM_BG      = 6,
    parameter int BG_FRAMES   = 120,
    parameter int WIN_X0      = 760,
    parameter int WIN_Y0      = 474,
    parameter int WIN_W       = 400,
    parameter int WIN_H       = 176,
    parameter int ROM_W       = 200,
    parameter int SCALE_SHIFT = 1,
    parameter int FRAME_SIZE  = 17600,
    parameter int ADDR_W      = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cen_i,
    input  logic [1:0]        vh_blank_i,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_op_i,
    output logic              cmd_ready_o,
    output logic [11:0]       hcount_o,
    output logic [11:0]       vcount_o,
    output logic [7:0]        frame_idx_o,
    output logic [2:0]        bg_idx_o,
    output logic              frame_tick_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              win_active_o,
    output logic [1:0]        state_o
);
    typedef enum logic [1:0] {PLAY = 2'd0, PAUSE = 2'd1, STEP_PEND = 2'd2} state_t;
    localparam logic [1:0] OP_PLAY = 2'd0, OP_PAUSE = 2'd1, OP_STEP = 2'd2, OP_RESTART = 2'd3;

    state_t             state_q;
    logic               hb_q, vb_q, tick_q;
    logic [11:0]        hcount_q, vcount_q, xrel_q, yrel_q;
    logic [7:0]         frame_q;
    logic [2:0]         bg_q;
    logic [15:0]        delay_q, bgcnt_q;
    logic               in_win_q, win_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               h_f, h_r, v_r, acc, in_win_d;
    logic [7:0]         frame_d;
    logic [2:0]         bg_d;
    logic [ADDR_W-1:0]  addr_d;

    always_comb begin
        h_f      = ~vh_blank_i[0] & hb_q;
        h_r      = vh_blank_i[0] & ~hb_q;
        v_r      = vh_blank_i[1] & ~vb_q;
        acc      = cmd_valid_i & cmd_ready_o & cen_i;
        frame_d  = (frame_q == 8'(NUM_FRAMES - 1)) ? 8'd0 : frame_q + 8'd1;
        bg_d     = (bg_q == 3'(NUM_BG - 1)) ? 3'd0 : bg_q + 3'd1;
        in_win_d = (hcount_q >= 12'(WIN_X0)) && (hcount_q < 12'(WIN_X0 + WIN_W)) &&
                   (vcount_q >= 12'(WIN_Y0)) && (vcount_q < 12'(WIN_Y0 + WIN_H));
        addr_d   = ADDR_W'(frame_q) * ADDR_W'(FRAME_SIZE) +
                   ADDR_W'(yrel_q >> SCALE_SHIFT) * ADDR_W'(ROM_W) +
                   ADDR_W'(xrel_q >> SCALE_SHIFT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= PLAY;
            hb_q     <= 1'b0;
            vb_q     <= 1'b0;
            tick_q   <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            xrel_q   <= '0;
            yrel_q   <= '0;
            frame_q  <= '0;
            bg_q     <= '0;
            delay_q  <= '0;
            bgcnt_q  <= '0;
            in_win_q <= 1'b0;
            win_q    <= 1'b0;
            addr_q   <= '0;
        end else if (cen_i) begin
            hb_q     <= vh_blank_i[0];
            vb_q     <= vh_blank_i[1];
            tick_q   <= v_r;
            hcount_q <= h_f ? 12'd0 : (&hcount_q) ? hcount_q : hcount_q + 12'd1;
            vcount_q <= v_r ? 12'd0 : (h_r && !(&vcount_q)) ? vcount_q + 12'd1 : vcount_q;
            // Restart outranks everything, including a coincident frame tick
            if (acc && cmd_op_i == OP_RESTART) begin
                state_q <= PLAY;
                frame_q <= '0;
                bg_q    <= '0;
                delay_q <= '0;
                bgcnt_q <= '0;
            end else begin
                case (state_q)
                    PLAY: begin
                        if (acc && cmd_op_i == OP_PAUSE) state_q <= PAUSE;
                        if (v_r) begin
                            delay_q <= (delay_q == 16'(FRAME_DELAY - 1)) ? 16'd0 : delay_q + 16'd1;
                            if (delay_q == 16'(FRAME_DELAY - 1)) frame_q <= frame_d;
                            bgcnt_q <= (bgcnt_q == 16'(BG_FRAMES - 1)) ? 16'd0 : bgcnt_q + 16'd1;
                            if (bgcnt_q == 16'(BG_FRAMES - 1)) bg_q <= bg_d;
                        end
                    end
                    PAUSE: begin
                        if (acc && cmd_op_i == OP_PLAY) state_q <= PLAY;
                        if (acc && cmd_op_i == OP_STEP) state_q <= STEP_PEND;
                    end
                    STEP_PEND: begin
                        if (v_r) begin
                            frame_q <= frame_d;
                            state_q <= PAUSE;
                        end
                    end
                    default: state_q <= PLAY;
                endcase
            end
            in_win_q <= in_win_d;
            xrel_q   <= hcount_q - 12'(WIN_X0);
            yrel_q   <= vcount_q - 12'(WIN_Y0);
            win_q    <= in_win_q;
            addr_q   <= in_win_q ? addr_d : '0;
        end
    end

    assign cmd_ready_o  = (state_q != STEP_PEND);
    assign hcount_o     = hcount_q;
    assign vcount_o     = vcount_q;
    assign frame_idx_o  = frame_q;
    assign bg_idx_o     = bg_q;
    assign frame_tick_o = tick_q;
    assign rom_addr_o   = addr_q;
    assign win_active_o = win_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_anim_overlay_ctrl.sv
// tb_anim_overlay_ctrl: table-driven scheduler vectors plus directed handshake, restart, window and cen-freeze sequences
module tb_anim_overlay_ctrl;
    logic        clk = 1'b0;
    logic        rst, cen, cmd_valid, cmd_ready, frame_tick, win_active;
    logic [1:0]  vh_blank, cmd_op, state;
    logic [11:0] hcount, vcount;
    logic [7:0]  frame_idx;
    logic [2:0]  bg_idx;
    logic [19:0] rom_addr;
    int          n_cmp = 0, n_bad = 0, n_ticks = 0;

    typedef struct {
        int kind;
        int n;
        int frame;
        int bg;
        int state;
    } vec_t;
    vec_t tbl[15];

    always #5 clk = ~clk;

    anim_overlay_ctrl dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .vh_blank_i(vh_blank),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_ready_o(cmd_ready),
        .hcount_o(hcount), .vcount_o(vcount), .frame_idx_o(frame_idx),
        .bg_idx_o(bg_idx), .frame_tick_o(frame_tick), .rom_addr_o(rom_addr),
        .win_active_o(win_active), .state_o(state)
    );

    always @(negedge clk) if (frame_tick === 1'b1) n_ticks++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] vh);
        vh_blank = vh;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        cyc(2'b10);
        cyc(2'b00);
    endtask

    task automatic cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cyc(2'b00);
        cmd_valid = 1'b0;
    endtask

    task automatic line(input int k);
        cyc(2'b01);
        repeat (k) cyc(2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 3,   0,  0, 0};
        tbl[1]  = '{0, 1,   1,  0, 0};
        tbl[2]  = '{0, 4,   2,  0, 0};
        tbl[3]  = '{0, 108, 29, 0, 0};
        tbl[4]  = '{0, 3,   29, 0, 0};
        tbl[5]  = '{0, 1,   0,  1, 0};
        tbl[6]  = '{0, 480, 0,  5, 0};
        tbl[7]  = '{0, 120, 0,  0, 0};
        tbl[8]  = '{1, 1,   0,  0, 1};
        tbl[9]  = '{0, 10,  0,  0, 1};
        tbl[10] = '{1, 0,   0,  0, 0};
        tbl[11] = '{0, 3,   0,  0, 0};
        tbl[12] = '{0, 1,   1,  0, 0};
        tbl[13] = '{1, 2,   1,  0, 0};
        tbl[14] = '{1, 3,   0,  0, 0};
        rst = 1'b1; cen = 1'b0; vh_blank = 2'b00; cmd_valid = 1'b0; cmd_op = 2'd0;
        repeat (3) cyc(2'b00);
        chk("rst_hcount", hcount, 0);
        chk("rst_vcount", vcount, 0);
        chk("rst_frame", frame_idx, 0);
        chk("rst_bg", bg_idx, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_win", win_active, 0);
        chk("rst_state", state, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b0; cen = 1'b1;
        for (int i = 0; i < 15; i++) begin
            int t0;
            t0 = n_ticks;
            if (tbl[i].kind == 0) repeat (tbl[i].n) tick();
            else cmd(2'(tbl[i].n));
            chk($sformatf("v%0d_frame", i), frame_idx, tbl[i].frame);
            chk($sformatf("v%0d_bg", i), bg_idx, tbl[i].bg);
            chk($sformatf("v%0d_state", i), state, tbl[i].state);
            chk($sformatf("v%0d_ready", i), cmd_ready, 1);
            chk($sformatf("v%0d_pulses", i), n_ticks - t0, (tbl[i].kind == 0) ? tbl[i].n : 0);
        end
        // single-step handshake with a held second STEP
        cmd(2'd1);
        cmd(2'd2);
        chk("step_state", state, 2);
        chk("step_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_op = 2'd2;
        repeat (3) cyc(2'b00);
        chk("step_hold_ready", cmd_ready, 0);
        chk("step_hold_frame", frame_idx, 0);
        cyc(2'b10);
        chk("step_adv_frame", frame_idx, 1);
        chk("step_adv_state", state, 1);
        chk("step_adv_ready", cmd_ready, 1);
        cyc(2'b00);
        cmd_valid = 1'b0;
        chk("step2_state", state, 2);
        repeat (2) cyc(2'b00);
        chk("step2_wait_frame", frame_idx, 1);
        tick();
        chk("step2_frame", frame_idx, 2);
        chk("step2_state_after", state, 1);
        // restart coincident with a tick at frame 7
        cmd(2'd0);
        cmd(2'd3);
        repeat (31) tick();
        chk("pre_rst_frame", frame_idx, 7);
        cmd_valid = 1'b1; cmd_op = 2'd3;
        cyc(2'b10);
        cmd_valid = 1'b0;
        chk("corst_frame", frame_idx, 0);
        chk("corst_bg", bg_idx, 0);
        chk("corst_state", state, 0);
        cyc(2'b00);
        repeat (3) tick();
        chk("corst_delay_clr", frame_idx, 0);
        tick();
        chk("corst_next", frame_idx, 1);
        // window addressing at frame 3
        cmd(2'd3);
        repeat (12) tick();
        chk("win_frame", frame_idx, 3);
        chk("win_v0", vcount, 0);
        repeat (473) line(1);
        line(761);
        chk("win_h760", hcount, 760);
        chk("win_v474", vcount, 474);
        chk("win_pre_edge", win_active, 0);
        repeat (2) cyc(2'b00);
        chk("win_tl_active", win_active, 1);
        chk("win_tl_addr", rom_addr, 52800);
        repeat (397) cyc(2'b00);
        chk("win_h1159", hcount, 1159);
        repeat (2) cyc(2'b00);
        chk("win_tr_addr", rom_addr, 52999);
        cyc(2'b00);
        chk("win_right_active", win_active, 0);
        chk("win_right_addr", rom_addr, 0);
        repeat (174) line(1);
        line(1001);
        chk("win_v649", vcount, 649);
        repeat (2) cyc(2'b00);
        chk("frz_pre_addr", rom_addr, 70320);
        cen = 1'b0;
        repeat (5) cyc(2'b11);
        chk("frz_hcount", hcount, 1002);
        chk("frz_vcount", vcount, 649);
        chk("frz_addr", rom_addr, 70320);
        chk("frz_win", win_active, 1);
        chk("frz_tick", frame_tick, 0);
        cen = 1'b1;
        cyc(2'b00);
        chk("res_hcount", hcount, 1003);
        chk("res_addr1", rom_addr, 70320);
        cyc(2'b00);
        chk("res_addr2", rom_addr, 70321);
        repeat (155) cyc(2'b00);
        repeat (2) cyc(2'b00);
        chk("win_br_addr", rom_addr, 70399);
        chk("win_br_active", win_active, 1);
        cyc(2'b00);
        chk("win_br_out", win_active, 0);
        line(761);
        repeat (2) cyc(2'b00);
        chk("win_below_active", win_active, 0);
        chk("win_below_addr", rom_addr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
